chaos_packer: RTL and testbench
===============================

# chaos_packer

Downstream consumer of the chaotic LFSR's serial output bit. It applies an optional von Neumann debiaser, packs the surviving bits MSB-first into WIDTH-bit words, and presents each word on a valid/ready output port. A repetition-count health test runs on the raw bit stream and latches a failure flag.

## Interface
- WIDTH, 8, output word width; must be ≥2.
- REP_LIMIT, 16, consecutive identical raw bits that trip the health test; must be ≥2.

- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  raw chaotic bit from the generator.
- bit_en  input  1  bit_in is accepted this cycle when 1; tie to 1 for one bit per clock.
- debias_en  input  1  1 = von Neumann debiasing on, 0 = pass-through.
- word_out  output  WIDTH  packed word; stable while word_valid=1.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out when word_valid=1.
- overflow  output  1  sticky; a completed word was dropped because of backpressure.
- health_fail  output  1  sticky; the repetition-count test tripped.

## Operation
- Reset, asynchronous on rst=1: word_out=0, word_valid=0, overflow=0, health_fail=0. The shift register, the bit counter, the pair phase, the pair register and the run counter all clear.
- Bit emission with debias_en=0: every accepted bit (bit_en=1) is emitted.
- Bit emission with debias_en=1:
  - Accepted bits are grouped in pairs.
  - On the first bit of a pair, store it and set pair_phase=1.
  - On the second bit, clear pair_phase. If the two bits differ, emit the first bit (10→1, 01→0). If they are equal (00/11), emit nothing.
- Pair-phase hold: pair_phase is forced to 0 whenever debias_en=0, so re-enabling debias always starts a fresh pair.
- Packing:
  - An emitted bit shifts in as shreg <= {shreg[WIDTH-2:0], b}, so the first emitted bit ends up as the MSB.
  - A bit counter runs 0..WIDTH-1.
  - An emit with counter=WIDTH-1 completes a word and wraps the counter to 0.
- Word completion:
  - If word_valid=0, or word_valid&word_ready in the same cycle, load word_out with the completed word and set word_valid=1.
  - Otherwise drop the word and set overflow=1. word_out keeps the held word.
- Handshake:
  - word_valid clears on a cycle with word_valid&word_ready, unless a new word loads in that same cycle.
  - word_out must not change while word_valid=1 and word_ready=0.
- Health test:
  - Operates on raw accepted bits, independent of debias_en.
  - The run counter is set to 1 on a bit that differs from the previous accepted bit, or on the first bit after reset. It increments on an equal bit and saturates at REP_LIMIT.
  - health_fail sets on the edge where the run counter reaches REP_LIMIT.
- After a health failure:
  - While health_fail=1, completed words are discarded without loading and without setting overflow.
  - A word already in word_out is still deliverable.
- Sticky flags: overflow and health_fail clear only on rst.

## Timing
- Latency: word_valid rises on the same clock edge that captures the word's last emitted bit. word_out is registered; there is no combinational path from bit_in to outputs.
- Throughput: one word per WIDTH accepted bits with debias off; on average ≥2·WIDTH bits with debias on.
- Consumption: a consumer holding word_ready=1 continuously can absorb back-to-back words with no overflow.
- bit_en=0 cycles: no state changes except the handshake.
- Reset mid-word: a partially packed word is lost. The next word requires WIDTH fresh emitted bits.

## Test plan
- Pass-through: debias_en=0, word_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles → word_out=8'hB2, word_valid=1 for exactly one cycle after the 8th edge. overflow=0.
- Debias: debias_en=1, raw pairs 10,01,11,10,00,10,01,01,10,01 → emitted bits 1,0,1,1,0,0,1,0 → word_out=8'hB2. The 11 and 00 pairs contribute nothing.
- Backpressure: word_ready=0, 16 pass-through bits forming 8'hA5 then 8'h3C → word_out holds 8'hA5 and overflow=1 after the 16th bit. Then raise word_ready → 8'hA5 is delivered once, word_valid=0, and 8'h3C never appears.
- Simultaneous complete+consume: a word is held and word_ready=1 on the completion edge of the next word → the new word loads, word_valid stays 1, overflow=0.
- Health test (REP_LIMIT=16):
  - 15 ones followed by a 0 → health_fail=0.
  - 16 consecutive ones → health_fail=1 on the 16th edge.
  - Subsequent completed words never assert word_valid.
- Reset mid-operation: after 5 bits, pulse rst asynchronously between edges → all outputs 0 immediately. The next word appears only after 8 new bits.

Source files
------------

// File: rtl/chaos_packer.sv
// Packs the chaotic generator's serial bits (optionally von Neumann debiased) MSB-first
// into words on a valid/ready port, with a sticky repetition-count health monitor on the raw stream.
module chaos_packer #(
    parameter int WIDTH     = 8,
    parameter int REP_LIMIT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             bit_in_i,
    input  logic             bit_en_i,
    input  logic             debias_en_i,
    output logic [WIDTH-1:0] word_out_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic             overflow_o,
    output logic             health_fail_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(REP_LIMIT);

    logic             pair_phase_q, pair_phase_d;
    logic             pair_bit_q, pair_bit_d;
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             health_q, health_d;
    logic [RW-1:0]    run_q, run_d;
    logic             prev_q, prev_d;
    logic             seen_q, seen_d;

    logic             emit;
    logic             emit_bit;
    logic             complete;
    logic [WIDTH-1:0] full_word;

    // Debias: the first bit of a pair is parked; a differing second bit releases the first.
    always_comb begin
        pair_phase_d = pair_phase_q;
        pair_bit_d   = pair_bit_q;
        emit         = 1'b0;
        emit_bit     = bit_in_i;
        if (!debias_en_i) begin
            pair_phase_d = 1'b0;
            emit         = bit_en_i;
        end else if (bit_en_i) begin
            if (!pair_phase_q) begin
                pair_phase_d = 1'b1;
                pair_bit_d   = bit_in_i;
            end else begin
                pair_phase_d = 1'b0;
                emit         = pair_bit_q ^ bit_in_i;
                emit_bit     = pair_bit_q;
            end
        end
    end

    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        complete  = 1'b0;
        full_word = {shreg_q, emit_bit};
        if (emit) begin
            shreg_d = full_word[WIDTH-2:0];
            if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Output port: a completed word loads if the slot is empty or being drained this cycle.
    always_comb begin
        word_d     = word_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        if (valid_q && word_ready_i) begin
            valid_d = 1'b0;
        end
        if (complete && !health_q) begin
            if (!valid_q || word_ready_i) begin
                word_d  = full_word;
                valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_comb begin
        run_d    = run_q;
        prev_d   = prev_q;
        seen_d   = seen_q;
        health_d = health_q;
        if (bit_en_i) begin
            prev_d = bit_in_i;
            seen_d = 1'b1;
            if (!seen_q || (bit_in_i != prev_q)) begin
                run_d = RW'(1);
            end else if (run_q != RUN_MAX) begin
                run_d = run_q + 1'b1;
            end
        end
        if (run_d == RUN_MAX) begin
            health_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pair_phase_q <= 1'b0;
            pair_bit_q   <= 1'b0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            valid_q      <= 1'b0;
            overflow_q   <= 1'b0;
            health_q     <= 1'b0;
            run_q        <= '0;
            prev_q       <= 1'b0;
            seen_q       <= 1'b0;
        end else begin
            pair_phase_q <= pair_phase_d;
            pair_bit_q   <= pair_bit_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            valid_q      <= valid_d;
            overflow_q   <= overflow_d;
            health_q     <= health_d;
            run_q        <= run_d;
            prev_q       <= prev_d;
            seen_q       <= seen_d;
        end
    end

    assign word_out_o    = word_q;
    assign word_valid_o  = valid_q;
    assign overflow_o    = overflow_q;
    assign health_fail_o = health_q;

endmodule

// File: tb/tb_chaos_packer.sv
// Directed bench for chaos_packer: pass-through, debias, backpressure, health test and reset.
module tb_chaos_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_en = 1'b0;
    logic       debias_en = 1'b0;
    logic       word_ready = 1'b0;
    logic [7:0] word_out;
    logic       word_valid;
    logic       overflow;
    logic       health_fail;

    int checks = 0;
    int errors = 0;

    chaos_packer #(.WIDTH(8), .REP_LIMIT(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bit_in_i      (bit_in),
        .bit_en_i      (bit_en),
        .debias_en_i   (debias_en),
        .word_out_o    (word_out),
        .word_valid_o  (word_valid),
        .word_ready_i  (word_ready),
        .overflow_o    (overflow),
        .health_fail_o (health_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic b, input logic en);
        @(negedge clk);
        bit_in = b;
        bit_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bit_en = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [19:0] db_bits;
        logic [7:0]  pt;

        #3;
        chk("rst_word", word_out, 8'h00);
        chk("rst_valid", {7'd0, word_valid}, 8'd0);
        chk("rst_ovf", {7'd0, overflow}, 8'd0);
        chk("rst_health", {7'd0, health_fail}, 8'd0);

        // Pass-through
        do_reset();
        word_ready = 1'b1;
        pt = 8'hB2;
        for (int i = 7; i >= 1; i--) step(pt[i], 1'b1);
        chk("pt_valid_early", {7'd0, word_valid}, 8'd0);
        step(pt[0], 1'b1);
        chk("pt_valid", {7'd0, word_valid}, 8'd1);
        chk("pt_word", word_out, 8'hB2);
        chk("pt_ovf", {7'd0, overflow}, 8'd0);
        step(1'b0, 1'b0);
        chk("pt_valid_drop", {7'd0, word_valid}, 8'd0);

        // Debias: 10 01 11 10 00 10 01 01 10 01
        do_reset();
        debias_en = 1'b1;
        db_bits = 20'b10_01_11_10_00_10_01_01_10_01;
        for (int i = 19; i >= 1; i--) step(db_bits[i], 1'b1);
        chk("db_valid_early", {7'd0, word_valid}, 8'd0);
        step(db_bits[0], 1'b1);
        chk("db_valid", {7'd0, word_valid}, 8'd1);
        chk("db_word", word_out, 8'hB2);
        step(1'b0, 1'b0);
        chk("db_valid_drop", {7'd0, word_valid}, 8'd0);

        // Backpressure
        do_reset();
        debias_en = 1'b0;
        word_ready = 1'b0;
        send_byte(8'hA5);
        chk("bp_valid1", {7'd0, word_valid}, 8'd1);
        chk("bp_word1", word_out, 8'hA5);
        chk("bp_ovf1", {7'd0, overflow}, 8'd0);
        send_byte(8'h3C);
        chk("bp_word2", word_out, 8'hA5);
        chk("bp_valid2", {7'd0, word_valid}, 8'd1);
        chk("bp_ovf2", {7'd0, overflow}, 8'd1);
        word_ready = 1'b1;
        step(1'b0, 1'b0);
        chk("bp_valid_drain", {7'd0, word_valid}, 8'd0);
        chk("bp_ovf_sticky", {7'd0, overflow}, 8'd1);
        step(1'b0, 1'b0);
        chk("bp_valid_stays", {7'd0, word_valid}, 8'd0);

        // Simultaneous complete and consume
        do_reset();
        word_ready = 1'b0;
        send_byte(8'h5A);
        chk("sim_word1", word_out, 8'h5A);
        pt = 8'hC3;
        for (int i = 7; i >= 1; i--) step(pt[i], 1'b1);
        chk("sim_hold", word_out, 8'h5A);
        word_ready = 1'b1;
        step(pt[0], 1'b1);
        chk("sim_word2", word_out, 8'hC3);
        chk("sim_valid", {7'd0, word_valid}, 8'd1);
        chk("sim_ovf", {7'd0, overflow}, 8'd0);
        step(1'b0, 1'b0);
        chk("sim_drain", {7'd0, word_valid}, 8'd0);

        // Health test
        do_reset();
        word_ready = 1'b1;
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("hl_15ones", {7'd0, health_fail}, 8'd0);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
        chk("hl_run15", {7'd0, health_fail}, 8'd0);
        step(1'b1, 1'b1);
        chk("hl_run16", {7'd0, health_fail}, 8'd1);
        step(1'b0, 1'b0);
        chk("hl_idle_valid", {7'd0, word_valid}, 8'd0);
        pt = 8'hAA;
        for (int i = 7; i >= 0; i--) begin
            step(pt[i], 1'b1);
            chk("hl_no_valid", {7'd0, word_valid}, 8'd0);
        end
        chk("hl_no_ovf", {7'd0, overflow}, 8'd0);
        chk("hl_sticky", {7'd0, health_fail}, 8'd1);

        // Reset mid-operation
        do_reset();
        word_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h3C);
        chk("mr_pre_ovf", {7'd0, overflow}, 8'd1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0 == 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_word", word_out, 8'h00);
        chk("mr_valid", {7'd0, word_valid}, 8'd0);
        chk("mr_ovf", {7'd0, overflow}, 8'd0);
        #1;
        rst = 1'b0;
        word_ready = 1'b1;
        pt = 8'h96;
        for (int i = 7; i >= 1; i--) begin
            step(pt[i], 1'b1);
            chk("mr_no_early", {7'd0, word_valid}, 8'd0);
        end
        step(pt[0], 1'b1);
        chk("mr_valid_new", {7'd0, word_valid}, 8'd1);
        chk("mr_word_new", word_out, 8'h96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
